retire_trace_buf: RTL and testbench

//  Retirement trace buffer. It sits directly downstream of the 5-stage pipeline's WB stage.
//  On every valid WB retirement it captures one record: sequence number, PC, instruction,
//  rd, write-enable and write-back data. Records go into a FIFO that a testbench, debug

---
 rtl/retire_trace_buf.sv | 156 +++++++++++++++
 tb/tb_retire_trace_buf.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/retire_trace_buf.sv
// retire_trace_buf: retirement trace FIFO fed by the WB stage, drained over valid/ready.
// Never back-pressures the pipeline; on overflow records are dropped or capture freezes.
module retire_trace_buf #(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned ADDR_W       = 4,
    parameter bit          STOP_ON_FULL = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear,
    input  logic              wb_isValid,
    input  logic [31:0]       wb_pc,
    input  logic [31:0]       wb_instr,
    input  logic [4:0]        wb_rd,
    input  logic              wb_regWrite,
    input  logic [31:0]       wb_data,
    input  logic              tr_ready,
    output logic              tr_valid,
    output logic [15:0]       tr_seq,
    output logic [31:0]       tr_pc,
    output logic [31:0]       tr_instr,
    output logic [4:0]        tr_rd,
    output logic              tr_we,
    output logic [31:0]       tr_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              overflow,
    output logic [15:0]       dropped_cnt,
    output logic [31:0]       retired_cnt
);

    typedef enum logic {
        ST_CAPTURE = 1'b0,
        ST_FROZEN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [15:0] seq;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] data;
    } rec_t;

    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W + 1)'(DEPTH);

    state_t             r_state;
    rec_t               r_mem [DEPTH];
    logic [ADDR_W-1:0]  r_wr_ptr;
    logic [ADDR_W-1:0]  r_rd_ptr;
    logic [ADDR_W:0]    r_count;
    logic               r_overflow;
    logic [15:0]        r_dropped;
    logic [31:0]        r_retired;

    logic               w_ev;
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    rec_t               w_new;
    rec_t               w_head;

    always_comb begin
        w_ev    = wb_isValid & enable;
        w_empty = (r_count == '0);
        w_full  = (r_count == LP_DEPTH);
        w_pop   = !w_empty & tr_ready;
        w_push  = w_ev & !clear & (r_state == ST_CAPTURE) & (!w_full | w_pop);
        w_drop  = w_ev & !clear & ((r_state == ST_FROZEN) | (w_full & !w_pop));
    end

    // seq is the low half of the retire counter: both start at 0 and step on every ev.
    always_comb begin
        w_new       = '0;
        w_new.seq   = r_retired[15:0];
        w_new.pc    = wb_pc;
        w_new.instr = wb_instr;
        w_new.rd    = wb_rd;
        w_new.we    = wb_regWrite & (wb_rd != 5'd0);
        w_new.data  = w_new.we ? wb_data : '0;
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_new;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_CAPTURE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_dropped  <= '0;
            r_retired  <= '0;
        end else begin
            if (w_ev) begin
                r_retired <= r_retired + 32'd1;
            end
            if (clear) begin
                r_state    <= ST_CAPTURE;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_count    <= '0;
                r_overflow <= 1'b0;
                r_dropped  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + (ADDR_W + 1)'(1);
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - (ADDR_W + 1)'(1);
                end
                if (w_drop) begin
                    r_overflow <= 1'b1;
                    if (r_dropped != '1) begin
                        r_dropped <= r_dropped + 16'd1;
                    end
                    if (STOP_ON_FULL) begin
                        r_state <= ST_FROZEN;
                    end
                end
            end
        end
    end

    // Head fields read 0 whenever the FIFO is empty, including straight out of reset.
    always_comb begin
        w_head = w_empty ? '0 : r_mem[r_rd_ptr];
    end

    assign tr_valid    = !w_empty;
    assign tr_seq      = w_head.seq;
    assign tr_pc       = w_head.pc;
    assign tr_instr    = w_head.instr;
    assign tr_rd       = w_head.rd;
    assign tr_we       = w_head.we;
    assign tr_data     = w_head.data;
    assign count       = r_count;
    assign full        = w_full;
    assign overflow    = r_overflow;
    assign dropped_cnt = r_dropped;
    assign retired_cnt = r_retired;

endmodule

// File: tb/tb_retire_trace_buf.sv
// Self-checking bench for retire_trace_buf: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_retire_trace_buf;

    localparam int unsigned DEPTH = 16;

    typedef struct packed {
        logic [15:0] seq;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] data;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset, enable, clear, wb_isValid, wb_regWrite, tr_ready;
    logic [31:0] wb_pc, wb_instr, wb_data;
    logic [4:0]  wb_rd;

    logic        tv0, tv1, twe0, twe1, fl0, fl1, ov0, ov1;
    logic [15:0] ts0, ts1, dc0, dc1;
    logic [31:0] tp0, tp1, ti0, ti1, td0, td1, rc0, rc1;
    logic [4:0]  trd0, trd1, cnt0, cnt1;

    retire_trace_buf #(.DEPTH(16), .ADDR_W(4), .STOP_ON_FULL(1'b0)) u_dut_drop (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear),
        .wb_isValid(wb_isValid), .wb_pc(wb_pc), .wb_instr(wb_instr), .wb_rd(wb_rd),
        .wb_regWrite(wb_regWrite), .wb_data(wb_data), .tr_ready(tr_ready),
        .tr_valid(tv0), .tr_seq(ts0), .tr_pc(tp0), .tr_instr(ti0), .tr_rd(trd0),
        .tr_we(twe0), .tr_data(td0), .count(cnt0), .full(fl0), .overflow(ov0),
        .dropped_cnt(dc0), .retired_cnt(rc0)
    );

    retire_trace_buf #(.DEPTH(16), .ADDR_W(4), .STOP_ON_FULL(1'b1)) u_dut_stop (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear),
        .wb_isValid(wb_isValid), .wb_pc(wb_pc), .wb_instr(wb_instr), .wb_rd(wb_rd),
        .wb_regWrite(wb_regWrite), .wb_data(wb_data), .tr_ready(tr_ready),
        .tr_valid(tv1), .tr_seq(ts1), .tr_pc(tp1), .tr_instr(ti1), .tr_rd(trd1),
        .tr_we(twe1), .tr_data(td1), .count(cnt1), .full(fl1), .overflow(ov1),
        .dropped_cnt(dc1), .retired_cnt(rc1)
    );

    always #5 clk = ~clk;

    // Reference model state
    rec_t        m_q[$];
    logic [31:0] m_ret;
    logic [15:0] m_drop;
    bit          m_ovf, m_frozen, m_stop;
    int          vectors = 0;
    int          errors  = 0;

    function automatic logic [118:0] obs_head(input bit sel);
        if (sel) return tv1 ? {tv1, ts1, tp1, ti1, trd1, twe1, td1} : '0;
        return tv0 ? {tv0, ts0, tp0, ti0, trd0, twe0, td0} : '0;
    endfunction

    function automatic logic [118:0] exp_head();
        if (m_q.size() == 0) return '0;
        return {1'b1, m_q[0]};
    endfunction

    function automatic logic [54:0] obs_stat(input bit sel);
        if (sel) return {cnt1, fl1, ov1, dc1, rc1};
        return {cnt0, fl0, ov0, dc0, rc0};
    endfunction

    function automatic logic [54:0] exp_stat();
        return {5'(m_q.size()), m_q.size() == DEPTH, m_ovf, m_drop, m_ret};
    endfunction

    task automatic model_step();
        bit   ev, pop, was_full;
        rec_t r;
        ev       = wb_isValid & enable;
        pop      = (m_q.size() != 0) && tr_ready;
        was_full = (m_q.size() == DEPTH);
        r.seq    = m_ret[15:0];
        r.pc     = wb_pc;
        r.instr  = wb_instr;
        r.rd     = wb_rd;
        r.we     = wb_regWrite && (wb_rd != 5'd0);
        r.data   = r.we ? wb_data : 32'd0;
        if (ev) m_ret++;
        if (clear) begin
            m_q.delete();
            m_ovf    = 0;
            m_drop   = '0;
            m_frozen = 0;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (ev) begin
                if (!m_frozen && (!was_full || pop)) begin
                    m_q.push_back(r);
                end else begin
                    m_ovf = 1;
                    if (m_drop != 16'hFFFF) m_drop++;
                    if (m_stop) m_frozen = 1;
                end
            end
        end
    endtask

    task automatic drive(input bit v, input bit rdy, input bit clr);
        wb_isValid  = v;
        tr_ready    = rdy;
        clear       = clr;
        wb_pc       = $urandom;
        wb_instr    = $urandom;
        wb_rd       = 5'($urandom);
        wb_regWrite = 1'($urandom);
        wb_data     = $urandom;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; clear = 1'b0; enable = 1'b1; wb_isValid = 1'b0; tr_ready = 1'b0;
        wb_pc = '0; wb_instr = '0; wb_rd = '0; wb_regWrite = 1'b0; wb_data = '0;
        m_q.delete(); m_ret = '0; m_drop = '0; m_ovf = 0; m_frozen = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        m_stop = 0;
        do_reset();
        vectors++;
        if ({tv0, ts0, tp0, ti0, trd0, twe0, td0, cnt0, fl0, ov0, dc0, rc0} !== '0) begin
            errors++;
            $display("FAIL reset_drop got=%h exp=0", {tv0, ts0, tp0, ti0, trd0, twe0, td0, cnt0, fl0, ov0, dc0, rc0});
        end
        vectors++;
        if ({tv1, ts1, tp1, ti1, trd1, twe1, td1, cnt1, fl1, ov1, dc1, rc1} !== '0) begin
            errors++;
            $display("FAIL reset_stop got=%h exp=0", {tv1, ts1, tp1, ti1, trd1, twe1, td1, cnt1, fl1, ov1, dc1, rc1});
        end
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0);
            wb_pc = 32'(4 * i);
            step();
        end
        vectors++;
        if ({cnt0, ts0, tp0, rc0} !== {5'd3, 16'd0, 32'h0, 32'd3}) begin
            errors++;
            $display("FAIL first3 count/seq/pc/retired got=%0d/%0d/%h/%0d exp=3/0/0/3", cnt0, ts0, tp0, rc0);
        end
        vectors++;
        if (obs_head(0) !== exp_head()) begin
            errors++;
            $display("FAIL first3_head got=%h exp=%h", obs_head(0), exp_head());
        end
    endtask

    task automatic test_writeback();
        m_stop = 0;
        do_reset();
        drive(1, 0, 0);
        wb_rd = 5'd0; wb_regWrite = 1'b1; wb_data = 32'd1;
        step();
        vectors++;
        if ({tv0, twe0, td0} !== {1'b1, 1'b0, 32'd0}) begin
            errors++;
            $display("FAIL x0_write valid/we/data got=%b/%b/%h exp=1/0/0", tv0, twe0, td0);
        end
        drive(1, 1, 0);
        wb_rd = 5'd5; wb_regWrite = 1'b1; wb_data = 32'hDEADBEEF;
        step();
        vectors++;
        if ({twe0, trd0, td0, cnt0} !== {1'b1, 5'd5, 32'hDEADBEEF, 5'd1}) begin
            errors++;
            $display("FAIL x5_write we/rd/data/count got=%b/%0d/%h/%0d exp=1/5/deadbeef/1", twe0, trd0, td0, cnt0);
        end
        vectors++;
        if (obs_head(0) !== exp_head()) begin
            errors++;
            $display("FAIL x5_head got=%h exp=%h", obs_head(0), exp_head());
        end
    endtask

    task automatic test_overflow_drain();
        m_stop = 0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, 0);
            step();
            vectors++;
            if (obs_stat(0) !== exp_stat()) begin
                errors++;
                $display("FAIL fill_stat cyc=%0d got=%h exp=%h", i, obs_stat(0), exp_stat());
            end
        end
        vectors++;
        if ({fl0, cnt0, ov0, dc0} !== {1'b1, 5'd16, 1'b1, 16'd4}) begin
            errors++;
            $display("FAIL overflow full/count/ovf/dropped got=%b/%0d/%b/%0d exp=1/16/1/4", fl0, cnt0, ov0, dc0);
        end
        for (int i = 0; i < 16; i++) begin
            drive(0, 1, 0);
            vectors++;
            if ({tv0, ts0} !== {1'b1, 16'(i)}) begin
                errors++;
                $display("FAIL drain_seq idx=%0d got=%b/%0d exp=1/%0d", i, tv0, ts0, i);
            end
            vectors++;
            if (obs_head(0) !== exp_head()) begin
                errors++;
                $display("FAIL drain_head idx=%0d got=%h exp=%h", i, obs_head(0), exp_head());
            end
            step();
        end
        vectors++;
        if ({tv0, cnt0} !== {1'b0, 5'd0}) begin
            errors++;
            $display("FAIL drained valid/count got=%b/%0d exp=0/0", tv0, cnt0);
        end
    endtask

    task automatic test_full_push_pop();
        m_stop = 0;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1, 0, 0);
            step();
        end
        drive(1, 1, 0);
        step();
        vectors++;
        if ({cnt0, fl0, ov0, dc0, ts0} !== {5'd16, 1'b1, 1'b0, 16'd0, 16'd1}) begin
            errors++;
            $display("FAIL full_pushpop count/full/ovf/dropped/seq got=%0d/%b/%b/%0d/%0d exp=16/1/0/0/1",
                     cnt0, fl0, ov0, dc0, ts0);
        end
        vectors++;
        if (obs_stat(0) !== exp_stat()) begin
            errors++;
            $display("FAIL full_pushpop_stat got=%h exp=%h", obs_stat(0), exp_stat());
        end
    endtask

    task automatic test_stop_on_full();
        m_stop = 1;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive(1, 0, 0);
            step();
        end
        vectors++;
        if ({cnt1, ov1, dc1} !== {5'd16, 1'b1, 16'd1}) begin
            errors++;
            $display("FAIL stop_overflow count/ovf/dropped got=%0d/%b/%0d exp=16/1/1", cnt1, ov1, dc1);
        end
        for (int i = 0; i < 16; i++) begin
            drive(0, 1, 0);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0);
            step();
        end
        vectors++;
        if ({cnt1, dc1, rc1} !== {5'd0, 16'd4, 32'd20}) begin
            errors++;
            $display("FAIL frozen count/dropped/retired got=%0d/%0d/%0d exp=0/4/20", cnt1, dc1, rc1);
        end
        drive(0, 0, 1);
        step();
        drive(1, 0, 0);
        step();
        vectors++;
        if ({cnt1, dc1, ov1, ts1} !== {5'd1, 16'd0, 1'b0, 16'd20}) begin
            errors++;
            $display("FAIL after_clear count/dropped/ovf/seq got=%0d/%0d/%b/%0d exp=1/0/0/20", cnt1, dc1, ov1, ts1);
        end
        vectors++;
        if (obs_head(1) !== exp_head()) begin
            errors++;
            $display("FAIL after_clear_head got=%h exp=%h", obs_head(1), exp_head());
        end
        m_stop = 0;
    endtask

    task automatic test_empty_and_async_reset();
        m_stop = 0;
        do_reset();
        drive(1, 1, 0);
        step();
        vectors++;
        if ({cnt0, tv0} !== {5'd1, 1'b1}) begin
            errors++;
            $display("FAIL empty_push count/valid got=%0d/%b exp=1/1", cnt0, tv0);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0);
            step();
        end
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 0);
            step();
        end
        vectors++;
        if (obs_stat(0) !== exp_stat()) begin
            errors++;
            $display("FAIL middrain_stat got=%h exp=%h", obs_stat(0), exp_stat());
        end
        drive(0, 1, 0);
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if ({tv0, ts0, tp0, ti0, trd0, twe0, td0, cnt0, fl0, ov0, dc0, rc0} !== '0) begin
            errors++;
            $display("FAIL async_reset got=%h exp=0", {tv0, ts0, tp0, ti0, trd0, twe0, td0, cnt0, fl0, ov0, dc0, rc0});
        end
    endtask

    task automatic test_random(input bit sel);
        m_stop = sel;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0,
                  (i % 120 < 60) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 79) == 0);
            enable = ($urandom_range(0, 7) != 0);
            step();
            vectors++;
            if (obs_stat(sel) !== exp_stat()) begin
                errors++;
                $display("FAIL rand_stat sel=%0d cyc=%0d got=%h exp=%h", sel, i, obs_stat(sel), exp_stat());
            end
            vectors++;
            if (obs_head(sel) !== exp_head()) begin
                errors++;
                $display("FAIL rand_head sel=%0d cyc=%0d got=%h exp=%h", sel, i, obs_head(sel), exp_head());
            end
        end
        enable = 1'b1;
    endtask

    initial begin
        test_reset();
        test_writeback();
        test_overflow_drain();
        test_full_push_pop();
        test_stop_on_full();
        test_empty_and_async_reset();
        test_random(0);
        test_random(1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
